// File: rtl/hamming_decode_sequencer_if.sv
// Codeword input and decoded-result output streams of the Hamming decode
// sequencer, each a valid/ready handshake.
interface hamming_decode_sequencer_if #(
    parameter int DATA_W = 64,
    parameter int CODE_W = 71,
    parameter int SYN_W  = 7
);
    logic              in_valid;
    logic              in_ready;
    logic [CODE_W-1:0] in_codeword;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CODE_W-1:0] out_corrected;
    logic [SYN_W-1:0]  out_syndrome;
    logic              out_err_corr;
    logic              out_err_uncorr;

    modport master (
        output in_valid,
        output in_codeword,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_corrected,
        input  out_syndrome,
        input  out_err_corr,
        input  out_err_uncorr
    );

    modport slave (
        input  in_valid,
        input  in_codeword,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_corrected,
        output out_syndrome,
        output out_err_corr,
        output out_err_uncorr
    );
endinterface

// File: rtl/hamming_decode_sequencer.sv
// Sequences codewords through an external combinational Hamming decoder,
// registers and classifies each result, and counts corrected/bad words.
module hamming_decode_sequencer #(
    parameter int DATA_W = 64,
    parameter int CODE_W = 71,
    parameter int SYN_W  = 7,
    parameter int CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    hamming_decode_sequencer_if.slave bus,
    output logic                      dec_enable,
    output logic [CODE_W-1:0]         dec_data_in,
    input  logic [CODE_W-1:0]         dec_corrected,
    input  logic [DATA_W-1:0]         dec_decoded,
    input  logic [SYN_W-1:0]          dec_syndrome,
    input  logic                      clr_counts,
    output logic [CNT_W-1:0]          corr_count,
    output logic [CNT_W-1:0]          uncorr_count,
    output logic                      busy
);
    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        OUTPUT
    } state_t;

    localparam logic [SYN_W-1:0] SYN_MAX = SYN_W'(CODE_W);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state;
    state_t            state_nxt;
    logic [CODE_W-1:0] cw_reg;
    logic              capture;
    logic              in_rdy;
    logic              is_corr;
    logic              is_uncorr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        in_rdy     = 1'b0;
        capture    = 1'b0;
        dec_enable = 1'b0;
        unique case (state)
            IDLE: begin
                in_rdy = 1'b1;
                if (bus.in_valid) begin
                    capture   = 1'b1;
                    state_nxt = DECODE;
                end
            end
            DECODE: begin
                dec_enable = 1'b1;
                state_nxt  = OUTPUT;
            end
            OUTPUT: begin
                if (bus.out_ready) begin
                    in_rdy = 1'b1;
                    if (bus.in_valid) begin
                        capture   = 1'b1;
                        state_nxt = DECODE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = (state == OUTPUT);
    assign busy          = (state != IDLE);
    assign dec_data_in   = cw_reg;

    // Syndromes beyond the last codeword position cannot name a bit to flip
    assign is_corr   = (dec_syndrome != '0) && (dec_syndrome <= SYN_MAX);
    assign is_uncorr = (dec_syndrome > SYN_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cw_reg             <= '0;
            bus.out_data       <= '0;
            bus.out_corrected  <= '0;
            bus.out_syndrome   <= '0;
            bus.out_err_corr   <= 1'b0;
            bus.out_err_uncorr <= 1'b0;
        end else begin
            if (capture) begin
                cw_reg <= bus.in_codeword;
            end
            if (state == DECODE) begin
                bus.out_data       <= dec_decoded;
                bus.out_syndrome   <= dec_syndrome;
                bus.out_corrected  <= is_uncorr ? cw_reg : dec_corrected;
                bus.out_err_corr   <= is_corr;
                bus.out_err_uncorr <= is_uncorr;
            end
        end
    end

    // Clear has priority over a same-edge increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_count   <= '0;
            uncorr_count <= '0;
        end else if (clr_counts) begin
            corr_count   <= '0;
            uncorr_count <= '0;
        end else if (state == DECODE) begin
            if (is_corr && (corr_count != CNT_MAX)) begin
                corr_count <= corr_count + CNT_W'(1);
            end
            if (is_uncorr && (uncorr_count != CNT_MAX)) begin
                uncorr_count <= uncorr_count + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_hamming_decode_sequencer.sv
// Bench for hamming_decode_sequencer: Hamming(71,64) decoder model,
// vector table, scoreboard queue and multi-cycle corner-case sequences.
module tb_hamming_decode_sequencer;
    localparam int DW  = 64;
    localparam int CW  = 71;
    localparam int SW  = 7;
    localparam int CNW = 2;
    localparam int PER = 10;
    localparam logic [CNW-1:0] CMAX = '1;

    typedef struct {
        logic [63:0] data;
        int          flip;
        bit          force_u;
        logic [6:0]  e_syn;
        bit          e_corr;
        bit          e_uncorr;
        logic [63:0] e_data;
    } vec_t;

    typedef struct {
        logic [70:0]    cw;
        logic [63:0]    data;
        logic [70:0]    cor;
        logic [6:0]     syn;
        bit             corr;
        bit             uncorr;
        logic [CNW-1:0] cc;
        logic [CNW-1:0] uc;
        time            t;
        bit             seen;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr_counts = 1'b0;
    logic force_syn = 1'b0;
    logic dec_enable;
    logic busy;
    logic [CW-1:0]  dec_data_in;
    logic [CW-1:0]  dec_corrected;
    logic [DW-1:0]  dec_decoded;
    logic [SW-1:0]  dec_syndrome;
    logic [CNW-1:0] corr_count;
    logic [CNW-1:0] uncorr_count;

    int checks = 0;
    int failures = 0;
    int n_push = 0;
    int n_pop = 0;
    exp_t q[$];
    bit pend = 1'b0;
    logic [CNW-1:0] ecc = '0;
    logic [CNW-1:0] euc = '0;

    hamming_decode_sequencer_if #(.DATA_W(DW), .CODE_W(CW), .SYN_W(SW)) bus ();

    hamming_decode_sequencer #(
        .DATA_W(DW), .CODE_W(CW), .SYN_W(SW), .CNT_W(CNW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus.slave),
        .dec_enable    (dec_enable),
        .dec_data_in   (dec_data_in),
        .dec_corrected (dec_corrected),
        .dec_decoded   (dec_decoded),
        .dec_syndrome  (dec_syndrome),
        .clr_counts    (clr_counts),
        .corr_count    (corr_count),
        .uncorr_count  (uncorr_count),
        .busy          (busy)
    );

    always #(PER/2) clk = ~clk;

    function automatic bit is_pow2(input int p);
        return (p & (p - 1)) == 0;
    endfunction

    function automatic logic [6:0] syn_of(input logic [70:0] cw);
        logic [6:0] s;
        s = '0;
        for (int p = 1; p <= 71; p++) begin
            if (cw[p-1]) s = s ^ 7'(p);
        end
        return s;
    endfunction

    function automatic logic [70:0] encode(input logic [63:0] d);
        logic [70:0] cw;
        logic [6:0] s;
        int k;
        cw = '0;
        k = 0;
        for (int p = 1; p <= 71; p++) begin
            if (!is_pow2(p)) begin
                cw[p-1] = d[k];
                k++;
            end
        end
        s = syn_of(cw);
        for (int b = 0; b < 7; b++) begin
            if (s[b]) cw[(1 << b) - 1] = 1'b1;
        end
        return cw;
    endfunction

    function automatic logic [63:0] extract(input logic [70:0] cw);
        logic [63:0] d;
        int k;
        d = '0;
        k = 0;
        for (int p = 1; p <= 71; p++) begin
            if (!is_pow2(p)) begin
                d[k] = cw[p-1];
                k++;
            end
        end
        return d;
    endfunction

    // Decoder model; force_syn emulates an out-of-range syndrome with junk correction
    always_comb begin
        logic [70:0] c;
        logic [6:0]  s;
        s = syn_of(dec_data_in);
        c = dec_data_in;
        if (s != 7'd0 && int'(s) <= 71) c[int'(s) - 1] = ~c[int'(s) - 1];
        dec_syndrome  = s;
        dec_corrected = c;
        dec_decoded   = extract(c);
        if (force_syn) begin
            dec_syndrome  = 7'd100;
            dec_corrected = ~dec_data_in;
            dec_decoded   = extract(dec_data_in);
        end
    end

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard: counters modelled at the DECODE edge, results popped on handshake
    always @(negedge clk) begin
        bit in_dec;
        if (!rst_n) begin
            q.delete();
            pend = 1'b0;
            ecc = '0;
            euc = '0;
        end else begin
            in_dec = pend;
            chk("dec_enable", 128'(dec_enable), 128'(in_dec));
            chk("busy", 128'(busy), 128'(in_dec || bus.out_valid));
            if (pend) begin
                pend = 1'b0;
                if (q.size() == 0) begin
                    chk("decode_without_word", 128'(1), 128'(0));
                end else begin
                    chk("dec_data_in", 128'(dec_data_in), 128'(q[q.size()-1].cw));
                    if (clr_counts) begin
                        ecc = '0;
                        euc = '0;
                    end else begin
                        if (q[q.size()-1].corr && ecc != CMAX) ecc = ecc + 1'b1;
                        if (q[q.size()-1].uncorr && euc != CMAX) euc = euc + 1'b1;
                    end
                    q[q.size()-1].cc = ecc;
                    q[q.size()-1].uc = euc;
                end
            end else if (clr_counts) begin
                ecc = '0;
                euc = '0;
            end
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_out_valid", 128'(1), 128'(0));
                end else begin
                    if (!q[0].seen) begin
                        q[0].seen = 1'b1;
                        chk("latency", 128'($time - q[0].t), 128'(2 * PER));
                    end
                    chk("out_data", 128'(bus.out_data), 128'(q[0].data));
                    chk("out_corrected", 128'(bus.out_corrected), 128'(q[0].cor));
                    chk("out_syndrome", 128'(bus.out_syndrome), 128'(q[0].syn));
                    chk("flags", 128'({bus.out_err_corr, bus.out_err_uncorr}),
                        128'({q[0].corr, q[0].uncorr}));
                    chk("counters", 128'({corr_count, uncorr_count}),
                        128'({q[0].cc, q[0].uc}));
                    chk("in_ready_output", 128'(bus.in_ready), 128'(bus.out_ready));
                    if (bus.out_ready) begin
                        void'(q.pop_front());
                        n_pop++;
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) pend = 1'b1;
        end
    end

    task automatic send(input logic [70:0] cw, input logic [63:0] ed,
                        input logic [6:0] es, input bit ec, input bit eu,
                        input bit with_clr);
        exp_t e;
        int n;
        @(posedge clk);
        #1;
        bus.in_valid    = 1'b1;
        bus.in_codeword = cw;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 50) begin
                chk("accept_timeout", 128'(1), 128'(0));
                break;
            end
        end
        e.cw     = cw;
        e.data   = ed;
        e.cor    = eu ? cw : encode(ed);
        e.syn    = es;
        e.corr   = ec;
        e.uncorr = eu;
        e.cc     = '0;
        e.uc     = '0;
        e.t      = $time;
        e.seen   = 1'b0;
        if (n <= 50) begin
            q.push_back(e);
            n_push++;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (with_clr) begin
            clr_counts = 1'b1;
            @(posedge clk);
            #1;
            clr_counts = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (q.size() == 0 && !busy) break;
            n++;
            if (n > 100) begin
                chk("idle_timeout", 128'(1), 128'(0));
                break;
            end
        end
    endtask

    function automatic logic [70:0] mk_cw(input vec_t v);
        logic [70:0] cw;
        cw = encode(v.data);
        if (v.flip > 0) cw[v.flip - 1] = ~cw[v.flip - 1];
        return cw;
    endfunction

    task automatic run_vec(input vec_t v, input bit with_clr);
        force_syn = v.force_u;
        send(mk_cw(v), v.e_data, v.e_syn, v.e_corr, v.e_uncorr, with_clr);
        wait_idle();
        force_syn = 1'b0;
    endtask

    initial begin
        vec_t vt[7];
        vec_t va;
        vec_t vb;
        int n;
        vt[0] = '{64'h0, 0, 1'b0, 7'd0, 1'b0, 1'b0, 64'h0};
        vt[1] = '{64'hA5A5_A5A5_5A5A_5A5A, 5, 1'b0, 7'd5, 1'b1, 1'b0,
                  64'hA5A5_A5A5_5A5A_5A5A};
        vt[2] = '{64'h0123_4567_89AB_CDEF, 1, 1'b0, 7'd1, 1'b1, 1'b0,
                  64'h0123_4567_89AB_CDEF};
        vt[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 71, 1'b0, 7'd71, 1'b1, 1'b0,
                  64'hFFFF_FFFF_FFFF_FFFF};
        vt[4] = '{64'hDEAD_BEEF_CAFE_F00D, 64, 1'b0, 7'd64, 1'b1, 1'b0,
                  64'hDEAD_BEEF_CAFE_F00D};
        vt[5] = '{64'hA5A5_A5A5_5A5A_5A5A, 0, 1'b1, 7'd100, 1'b0, 1'b1,
                  64'hA5A5_A5A5_5A5A_5A5A};
        vt[6] = '{64'h1111_2222_3333_4444, 3, 1'b1, 7'd100, 1'b0, 1'b1,
                  64'h1111_2222_3333_4445};

        bus.in_valid    = 1'b0;
        bus.in_codeword = '0;
        bus.out_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_outputs", 128'({bus.out_data, bus.out_syndrome,
            bus.out_err_corr, bus.out_err_uncorr}), 128'(0));
        chk("rst_counts", 128'({corr_count, uncorr_count}), 128'(0));
        chk("rst_dec_enable", 128'(dec_enable), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 128'(bus.in_ready), 128'(1));

        bus.out_ready = 1'b1;
        for (int i = 0; i < 7; i++) run_vec(vt[i], 1'b0);
        chk("table_corr_sat", 128'(corr_count), 128'(3));
        chk("table_uncorr", 128'(uncorr_count), 128'(2));

        // Backpressure with a second word waiting, then same-edge handoff
        va = '{64'h5555_AAAA_0F0F_F0F0, 9, 1'b0, 7'd9, 1'b1, 1'b0,
               64'h5555_AAAA_0F0F_F0F0};
        vb = '{64'h0BAD_F00D_1234_5678, 0, 1'b0, 7'd0, 1'b0, 1'b0,
               64'h0BAD_F00D_1234_5678};
        bus.out_ready = 1'b0;
        send(mk_cw(va), va.e_data, va.e_syn, va.e_corr, va.e_uncorr, 1'b0);
        fork
            send(mk_cw(vb), vb.e_data, vb.e_syn, vb.e_corr, vb.e_uncorr, 1'b0);
            begin
                repeat (6) @(posedge clk);
                #1;
                chk("stall_in_ready", 128'(bus.in_ready), 128'(0));
                chk("stall_out_valid", 128'(bus.out_valid), 128'(1));
                bus.out_ready = 1'b1;
            end
        join
        wait_idle();
        chk("no_loss_or_dup", 128'(n_pop), 128'(n_push));

        // Saturation then clear racing an increment
        @(posedge clk);
        #1;
        clr_counts = 1'b1;
        @(posedge clk);
        #1;
        clr_counts = 1'b0;
        @(negedge clk);
        chk("clr_idle", 128'({corr_count, uncorr_count}), 128'(0));
        for (int i = 0; i < 5; i++) begin
            va = '{64'h1000_0000_0000_0001 * (i + 1), 5 + i, 1'b0,
                   7'(5 + i), 1'b1, 1'b0, 64'h1000_0000_0000_0001 * (i + 1)};
            run_vec(va, 1'b0);
        end
        chk("corr_saturated", 128'(corr_count), 128'(3));
        va = '{64'hCAFE_0000_0000_BEEF, 13, 1'b0, 7'd13, 1'b1, 1'b0,
               64'hCAFE_0000_0000_BEEF};
        run_vec(va, 1'b1);
        chk("clear_beats_incr", 128'(corr_count), 128'(0));

        run_vec(vt[6], 1'b0);
        chk("uncorr_before_rst", 128'(uncorr_count), 128'(1));

        // Asynchronous reset while a word sits in DECODE
        send(mk_cw(vt[1]), vt[1].e_data, vt[1].e_syn, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("async_rst_counts", 128'({corr_count, uncorr_count}), 128'(0));
        chk("async_rst_busy", 128'({busy, dec_enable}), 128'(0));
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        n = 0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_idle", 128'({bus.out_valid, bus.in_ready, busy}),
                128'(3'b010));
        end
        chk("queue_empty", 128'(q.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hamming_decode_sequencer.md
Name: hamming_decode_sequencer

Overview:
Sequential controller that owns the combinational 64-bit Hamming decoder (71-bit codeword, 7-bit syndrome). It takes codewords over a valid/ready input stream, holds each one stable on the decoder for one decode cycle, and registers the decoded result. Results go out on a valid/ready output stream with error classification. It also keeps saturating counts of corrected and uncorrectable words for status readout.

Parameters:
DATA_W, 64, decoded payload width
CODE_W, 71, codeword width (DATA_W + SYN_W)
SYN_W, 7, syndrome width
CNT_W, 16, width of each error counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset; asynchronous and active-low
in_valid  input  1  input codeword valid
in_ready  output  1  controller can accept a codeword
in_codeword  input  CODE_W  received codeword
dec_enable  output  1  enable to decoder
dec_data_in  output  CODE_W  codeword driven to decoder
dec_corrected  input  CODE_W  decoder corrected codeword
dec_decoded  input  DATA_W  decoder payload
dec_syndrome  input  SYN_W  decoder syndrome (r)
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_data  output  DATA_W  registered payload
out_corrected  output  CODE_W  registered corrected codeword
out_syndrome  output  SYN_W  registered syndrome
out_err_corr  output  1  result had a single-bit error that was corrected
out_err_uncorr  output  1  syndrome out of range; payload not trusted
clr_counts  input  1  synchronous clear of both counters
corr_count  output  CNT_W  saturating count of corrected words
uncorr_count  output  CNT_W  saturating count of uncorrectable words
busy  output  1  state != IDLE

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; cw_reg=0.
  - All out_* = 0; out_valid=0.
  - Both counters = 0; dec_enable=0.
  - A word in flight is discarded; no partial output appears after release.
- States:
  - IDLE: in_ready=1. On in_valid: capture in_codeword into cw_reg, go to DECODE.
  - DECODE: lasts exactly one cycle. dec_enable=1 and dec_data_in=cw_reg. At the closing edge, register dec_decoded, dec_corrected and dec_syndrome, set the flags, update the counters, then go to OUTPUT.
  - OUTPUT: out_valid=1, all out_* held stable.
    - out_ready=0: stay in OUTPUT.
    - out_ready=1 and in_valid=1: capture the new word, go to DECODE. in_ready=1 in this case.
    - out_ready=1 and in_valid=0: go to IDLE.
- in_ready = (state==IDLE) or (state==OUTPUT and out_ready). It is 0 in DECODE.
- dec_data_in is always driven from cw_reg. dec_enable is 1 only in DECODE.
- Timing:
  - Latency: word accepted at edge N, out_valid=1 after edge N+2.
  - Peak throughput: one word per 2 cycles.
- Classification at the DECODE edge, with s = dec_syndrome:
  - s==0: both flags 0; out_data=dec_decoded.
  - 1 <= s <= CODE_W: out_err_corr=1; out_data=dec_decoded.
  - s > CODE_W (72..127): out_err_uncorr=1; out_data=dec_decoded unmodified; out_corrected=cw_reg.
  - The two flags are never 1 together.
- Counters:
  - corr_count += 1 on each corrected classification; uncorr_count += 1 on each uncorrectable one.
  - Both saturate at 2^CNT_W-1 and do not wrap.
  - clr_counts=1 zeroes both at the next edge. If clr_counts coincides with an increment, the clear wins and the result is 0.
  - Counters are unaffected by out_ready stalls.
- in_valid high while in DECODE, or in OUTPUT with out_ready=0: no capture. Upstream must hold the word.

Test Plan:
- Clean word: in_codeword = valid encoding of 64'h0 → out_valid 2 cycles after accept; out_data=0, out_syndrome=0, both flags 0, counters unchanged.
- Single-bit error: encoding of 64'hA5A5_A5A5_5A5A_5A5A with codeword bit position 5 flipped → out_syndrome=5, out_err_corr=1, out_data=64'hA5A5_A5A5_5A5A_5A5A, corr_count=1.
- Out-of-range syndrome: decoder model forced to dec_syndrome=7'd100 → out_err_uncorr=1, out_corrected=cw_reg, uncorr_count=1, corr_count unchanged.
- Backpressure and back-to-back: out_ready=0 for 5 cycles → out_* stable and in_ready=0 throughout. Then out_ready=1 with in_valid=1 on the same edge → new word captured, next result 2 cycles later, no word lost or duplicated.
- Saturation and clear (CNT_W=2): 5 corrected words → corr_count=3. Then clr_counts coinciding with a 6th corrected word → corr_count=0.
- Reset mid-operation: assert rst_n low during DECODE → out_valid=0 and counters=0 immediately, without waiting for a clock edge. After release, state IDLE with in_ready=1 and no stale output.
